sobel_linebuf_ctrl: RTL and testbench
=====================================

# sobel_linebuf_ctrl

Sequencing controller for the Sobel line buffer: it accepts a raster pixel stream and drives two external cascaded 2048-deep synchronous FIFOs (row-delay lines) so that three vertically aligned pixels (rows r-2, r-1, r) leave together on every column of rows 2..H-1. It sits between the pixel source and the 3x3 window/Sobel kernel. It owns FIFO write/read enables, FIFO reset, frame/line counting and error flagging.

## Interface
- DW, 24, pixel width
- IMG_W, 1920, pixels per line (2..2048)
- IMG_H, 1080, lines per frame (3..4095)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  source pixel valid
- in_ready  out  1  controller accepts pixel (beat = in_valid & in_ready)
- in_sof  in  1  first pixel of frame, qualified by in_valid
- in_data  in  DW  pixel
- fifo_rst  out  1  active-high reset to both FIFOs
- f0_we, f0_re  out  1  FIFO0 write/read enables
- f0_di  out  DW  FIFO0 write data
- f0_do  in  DW  FIFO0 read data, valid one cycle after f0_re (NOREG)
- f0_empty, f0_full  in  1  FIFO0 flags
- f1_we, f1_re  out  1  FIFO1 write/read enables
- f1_di  out  DW  FIFO1 write data (= f0_do)
- f1_do  in  DW  FIFO1 read data, one cycle after f1_re
- f1_empty, f1_full  in  1  FIFO1 flags
- tap_valid  out  1  taps valid
- tap0, tap1, tap2  out  DW  rows r-2, r-1, r at same column
- tap_sol, tap_eol  out  1  column 0 / column IMG_W-1 marker, qualified by tap_valid
- err  out  1  sticky error (overflow/underflow/mid-frame sof)

## Operation
- States: CLR, IDLE, ROW0, ROW1, RUN, DRAIN. Counters col (0..IMG_W-1), row (0..IMG_H-1), clog2 widths, wrap col→0 with row+1.
- CLR: fifo_rst=1, in_ready=0, lasts exactly 2 cycles, then IDLE. Reset state is CLR.
- IDLE: in_ready=1. Beats without in_sof are consumed and discarded. Beat with in_sof: becomes pixel (0,0), go ROW0.
- ROW0/ROW1/RUN: in_ready=1 unless in_valid&in_sof (mid-frame sof): then in_ready=0 combinationally, err set, go DRAIN; that beat is later accepted by IDLE.
- Per accepted pixel at row r: pixel registered; f0_we=1 next cycle with f0_di=pixel; f0_re=1 same cycle if r≥1. Cycle after f0_re: f1_we=1, f1_di=f0_do; f1_re=1 same cycle if r≥2.
- ROW0→ROW1 after col IMG_W-1 of row 0; ROW1→RUN after row 1; RUN→DRAIN after last pixel of row IMG_H-1.
- FIFO0 steady occupancy IMG_W, FIFO1 IMG_W; no FIFO ever exceeds IMG_W entries.
- DRAIN: in_ready=0 for 3 cycles (pipeline flush, taps still emitted), then CLR (discards residual rows).
- err set on: we while full, re while empty (either FIFO), mid-frame sof. Cleared only by rst_n or by the next accepted in_sof in IDLE.

## Timing
- Beat at cycle t (row r≥2): f0_we/f0_re at t+1, f1_we/f1_re at t+2, tap_valid at t+3 with tap2=pixel, tap1=f0_do, tap0=f1_do (latency 3). Rows 0/1 produce no taps.
- Bubbles in in_valid propagate as bubbles; no downstream backpressure.
- Reset (rst_n low, async): state CLR, counters 0, fifo_rst=1, in_ready=0, all enables 0, tap_valid=0, taps 0, tap_sol/eol 0, err 0.
- Frame-end gap: 5 cycles with in_ready=0 (3 DRAIN + 2 CLR).
- Last beat of frame with next sof on next cycle: held off until IDLE, then accepted.

## Test plan
- IMG_W=4, IMG_H=4, pixel value = row*16+col, continuous valid -> exactly 8 tap_valid cycles; first at 3 cycles after beat (2,0) with tap0=0x00, tap1=0x10, tap2=0x20; last tap0=0x13, tap1=0x23, tap2=0x33 with tap_eol=1.
- Same frame with random in_valid gaps -> identical tap sequence, err=0, FIFO occupancy never >4.
- Beats before any sof in IDLE -> discarded, no we, first tap still uses the sof pixel as (0,0).
- Mid-frame sof at (2,1) -> in_ready=0 that cycle, err=1, 3 DRAIN + 2 fifo_rst cycles, then new frame accepted and err cleared; taps match new frame.
- Force f0_empty=1 during row 1 read -> err=1 next cycle and stays 1 to end of frame.
- rst_n pulled low mid-RUN -> all outputs at reset values immediately; after release fifo_rst=1 for 2 cycles then in_ready=1.

Source files
------------

// File: rtl/sobel_linebuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sobel_linebuf_ctrl
// Function : Raster-to-3-row sequencer driving two cascaded row-delay FIFOs
//            so rows r-2, r-1, r of one column leave together as Sobel taps.
// Revision : 1.0
// ============================================================================
module sobel_linebuf_ctrl #(
  parameter int DW    = 24,
  parameter int IMG_W = 1920,
  parameter int IMG_H = 1080
) (
  input  logic          clk,
  input  logic          rst_n,
  // pixel source
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [DW-1:0] in_data,
  // row-delay FIFOs
  output logic          fifo_rst,
  output logic          f0_we,
  output logic          f0_re,
  output logic [DW-1:0] f0_di,
  input  logic [DW-1:0] f0_do,
  input  logic          f0_empty,
  input  logic          f0_full,
  output logic          f1_we,
  output logic          f1_re,
  output logic [DW-1:0] f1_di,
  input  logic [DW-1:0] f1_do,
  input  logic          f1_empty,
  input  logic          f1_full,
  // window taps
  output logic          tap_valid,
  output logic [DW-1:0] tap0,
  output logic [DW-1:0] tap1,
  output logic [DW-1:0] tap2,
  output logic          tap_sol,
  output logic          tap_eol,
  output logic          err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_CLR   = 3'd0,
    S_IDLE  = 3'd1,
    S_ROW0  = 3'd2,
    S_ROW1  = 3'd3,
    S_RUN   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t        state;
  logic [1:0]    phase_cnt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic active;
  logic mid_sof;
  logic beat;
  logic sof_beat;
  logic px_beat;
  logic px_ge1;
  logic px_ge2;
  logic px_sol;
  logic px_eol;
  logic col_last;
  logic fifo_err;

  // stage-1/2 side-band that travels alongside the FIFO reads
  logic          s1_ge2;
  logic          s1_sol;
  logic          s1_eol;
  logic [DW-1:0] s2_pix;
  logic          s2_sol;
  logic          s2_eol;

  assign active   = (state == S_ROW0) || (state == S_ROW1) || (state == S_RUN);
  assign mid_sof  = active && in_valid && in_sof;
  assign in_ready = (state == S_IDLE) || (active && !(in_valid && in_sof));
  assign beat     = in_valid && in_ready;
  assign sof_beat = beat && (state == S_IDLE) && in_sof;
  assign px_beat  = sof_beat || (beat && active);
  assign col_last = (col == COL_LAST);

  // the sof beat accepted in IDLE is pixel (0,0)
  assign px_ge1 = (state == S_ROW1) || (state == S_RUN);
  assign px_ge2 = (state == S_RUN);
  assign px_sol = (state == S_IDLE) || (col == '0);
  assign px_eol = active && col_last;

  assign fifo_rst = (state == S_CLR);
  assign f1_di    = f0_do;
  assign tap0     = tap_valid ? f1_do : '0;

  assign fifo_err = (f0_we && f0_full) || (f0_re && f0_empty) ||
                    (f1_we && f1_full) || (f1_re && f1_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CLR;
      phase_cnt <= 2'd0;
      col       <= '0;
      row       <= '0;
    end else begin
      case (state)
        S_CLR: begin
          col <= '0;
          row <= '0;
          if (phase_cnt == 2'd1) begin
            phase_cnt <= 2'd0;
            state     <= S_IDLE;
          end else begin
            phase_cnt <= phase_cnt + 2'd1;
          end
        end
        S_IDLE: begin
          if (sof_beat) begin
            col   <= CW'(1);
            row   <= '0;
            state <= S_ROW0;
          end
        end
        S_ROW0, S_ROW1, S_RUN: begin
          if (mid_sof) begin
            phase_cnt <= 2'd0;
            state     <= S_DRAIN;
          end else if (beat) begin
            if (col_last) begin
              col <= '0;
              row <= row + RW'(1);
              if (state == S_ROW0) begin
                state <= S_ROW1;
              end else if (state == S_ROW1) begin
                state <= S_RUN;
              end else if (row == ROW_LAST) begin
                phase_cnt <= 2'd0;
                state     <= S_DRAIN;
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          // three cycles let the last beat reach the taps before FIFO reset
          if (phase_cnt == 2'd2) begin
            phase_cnt <= 2'd0;
            state     <= S_CLR;
          end else begin
            phase_cnt <= phase_cnt + 2'd1;
          end
        end
        default: begin
          phase_cnt <= 2'd0;
          state     <= S_CLR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f0_we     <= 1'b0;
      f0_re     <= 1'b0;
      f0_di     <= '0;
      s1_ge2    <= 1'b0;
      s1_sol    <= 1'b0;
      s1_eol    <= 1'b0;
      f1_we     <= 1'b0;
      f1_re     <= 1'b0;
      s2_pix    <= '0;
      s2_sol    <= 1'b0;
      s2_eol    <= 1'b0;
      tap_valid <= 1'b0;
      tap1      <= '0;
      tap2      <= '0;
      tap_sol   <= 1'b0;
      tap_eol   <= 1'b0;
    end else begin
      f0_we  <= px_beat;
      f0_re  <= px_beat && px_ge1;
      s1_ge2 <= px_beat && px_ge2;
      s1_sol <= px_beat && px_sol;
      s1_eol <= px_beat && px_eol;
      if (px_beat) begin
        f0_di <= in_data;
      end

      f1_we  <= f0_re;
      f1_re  <= f0_re && s1_ge2;
      s2_sol <= s1_sol;
      s2_eol <= s1_eol;
      if (f0_re) begin
        s2_pix <= f0_di;
      end

      // f0_do is valid only in the cycle after f0_re, so capture it here
      tap_valid <= f1_re;
      tap_sol   <= f1_re && s2_sol;
      tap_eol   <= f1_re && s2_eol;
      if (f1_re) begin
        tap1 <= f0_do;
        tap2 <= s2_pix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= (err && !sof_beat) || fifo_err || mid_sof;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_linebuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_linebuf_ctrl
// Function : Scoreboard bench for sobel_linebuf_ctrl with behavioural FIFOs.
// Revision : 1.0
// ============================================================================
module tb_sobel_linebuf_ctrl;

  localparam int DW = 24;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_sof;
  logic [DW-1:0] in_data;
  logic          fifo_rst;
  logic          f0_we, f0_re, f0_empty, f0_full;
  logic          f1_we, f1_re, f1_empty, f1_full;
  logic [DW-1:0] f0_di, f0_do, f1_di, f1_do;
  logic          tap_valid, tap_sol, tap_eol, err;
  logic [DW-1:0] tap0, tap1, tap2;
  logic          force_e;

  typedef struct packed {
    logic [DW-1:0] t0;
    logic [DW-1:0] t1;
    logic [DW-1:0] t2;
    logic          sol;
    logic          eol;
  } tap_t;

  tap_t          exp_q[$];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int f0_cnt = 0, f1_cnt = 0;
  int total = 0, bad = 0;
  int cyc = 0, beat_cyc = 0, first_tap_cyc = -1;
  int tap_cnt = 0, we_cnt = 0, occ_viol = 0, peak0 = 0, peak1 = 0;
  int last_waits = 0, last_rsts = 0;

  sobel_linebuf_ctrl #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .fifo_rst(fifo_rst),
    .f0_we(f0_we), .f0_re(f0_re), .f0_di(f0_di), .f0_do(f0_do),
    .f0_empty(f0_empty), .f0_full(f0_full),
    .f1_we(f1_we), .f1_re(f1_re), .f1_di(f1_di), .f1_do(f1_do),
    .f1_empty(f1_empty), .f1_full(f1_full),
    .tap_valid(tap_valid), .tap0(tap0), .tap1(tap1), .tap2(tap2),
    .tap_sol(tap_sol), .tap_eol(tap_eol), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural 2048-deep FIFOs, read data appears the cycle after re
  assign f0_empty = (f0_cnt == 0) || force_e;
  assign f0_full  = (f0_cnt >= 2048);
  assign f1_empty = (f1_cnt == 0);
  assign f1_full  = (f1_cnt >= 2048);

  always @(posedge clk) begin
    if (fifo_rst) begin
      q0.delete();
      q1.delete();
      f0_do <= '0;
      f1_do <= '0;
    end else begin
      if (f0_re && q0.size() > 0) f0_do <= q0.pop_front();
      if (f0_we && q0.size() < 2048) q0.push_back(f0_di);
      if (f1_re && q1.size() > 0) f1_do <= q1.pop_front();
      if (f1_we && q1.size() < 2048) q1.push_back(f1_di);
    end
    f0_cnt <= q0.size();
    f1_cnt <= q1.size();
  end

  // monitor: pops the scoreboard whenever the DUT presents a tap
  initial begin
    tap_t act, e;
    forever begin
      @(negedge clk);
      if (f0_cnt > W || f1_cnt > W) occ_viol++;
      if (f0_cnt > peak0) peak0 = f0_cnt;
      if (f1_cnt > peak1) peak1 = f1_cnt;
      if (f0_we) we_cnt++;
      if (tap_valid) begin
        tap_cnt++;
        if (first_tap_cyc < 0) first_tap_cyc = cyc;
        act.t0 = tap0; act.t1 = tap1; act.t2 = tap2;
        act.sol = tap_sol; act.eol = tap_eol;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL tap_unexpected got t0=%h t1=%h t2=%h sol=%b eol=%b want none",
                   act.t0, act.t1, act.t2, act.sol, act.eol);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            bad++;
            $display("FAIL tap got t0=%h t1=%h t2=%h sol=%b eol=%b want t0=%h t1=%h t2=%h sol=%b eol=%b",
                     act.t0, act.t1, act.t2, act.sol, act.eol, e.t0, e.t1, e.t2, e.sol, e.eol);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int base, input int idx);
    return DW'(base + (idx / W) * 16 + (idx % W));
  endfunction

  function automatic tap_t mk(input int base, input int idx);
    tap_t t;
    t.t0  = pix(base, idx - 2 * W);
    t.t1  = pix(base, idx - W);
    t.t2  = pix(base, idx);
    t.sol = ((idx % W) == 0);
    t.eol = ((idx % W) == W - 1);
    return t;
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // called at a falling edge; returns at the falling edge after the beat
  task automatic send(input logic [DW-1:0] d, input logic sof, output int waits, output int rsts);
    bit ok;
    waits = 0;
    rsts  = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    forever begin
      #1;
      ok = in_ready;
      if (fifo_rst) rsts++;
      if (ok) beat_cyc = cyc;
      @(negedge clk);
      if (ok) break;
      waits++;
      if (waits > 40) begin
        total++;
        bad++;
        $display("FAIL send_timeout got waits=%0d want <=40", waits);
        break;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // linear pixel index i = row*W + col; taps are expected from row 2 on
  task automatic part(input int base, input int i0, input int i1, input bit rnd);
    int w, rs;
    for (int i = i0; i <= i1; i++) begin
      if (rnd) idle(int'($urandom_range(0, 2)));
      if (i >= 2 * W) exp_q.push_back(mk(base, i));
      send(pix(base, i), (i == 0), w, rs);
      last_waits = w;
      last_rsts  = rs;
    end
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_fifo_rst"}, fifo_rst, 1);
    chk({tag, "_enables"}, {f0_we, f0_re, f1_we, f1_re}, 0);
    chk({tag, "_flags"}, {tap_valid, tap_sol, tap_eol, err}, 0);
    chk({tag, "_taps"}, {tap0, tap1, tap2}, 0);
  endtask

  task automatic post_reset(input string tag);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_clr1"}, {fifo_rst, in_ready}, 2'b10);
    @(negedge clk);
    chk({tag, "_clr2"}, {fifo_rst, in_ready}, 2'b10);
    @(negedge clk);
    chk({tag, "_idle"}, {fifo_rst, in_ready}, 2'b01);
  endtask

  initial begin
    int w, rs, a_cyc;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; force_e = 1'b0;
    repeat (2) @(negedge clk);
    reset_vals("por");
    post_reset("por");

    // beats before any sof are swallowed without touching the FIFOs
    send(24'hBAD001, 1'b0, w, rs);
    chk("pre_sof_ready", w, 0);
    send(24'hBAD002, 1'b0, w, rs);
    send(24'hBAD003, 1'b0, w, rs);
    idle(3);
    chk("pre_sof_no_we", we_cnt, 0);

    // frame A then B back-to-back with continuous valid
    part(32'h000, 0, 8, 1'b0);
    a_cyc = beat_cyc;
    part(32'h000, 9, 15, 1'b0);
    part(32'h100, 0, 0, 1'b0);
    chk("frame_gap_waits", last_waits, 5);
    chk("frame_gap_rsts", last_rsts, 2);
    part(32'h100, 1, 15, 1'b0);
    idle(8);
    chk("taps_ab", tap_cnt, 16);
    chk("first_tap_latency", first_tap_cyc - a_cyc, 3);
    chk("err_ab", err, 0);

    // frame C with random bubbles
    part(32'h200, 0, 15, 1'b1);
    idle(8);
    chk("taps_c", tap_cnt, 24);
    chk("err_c", err, 0);

    // frame D aborted by a sof at (2,1); frame E starts from it
    part(32'h300, 0, 8, 1'b0);
    in_valid = 1'b1; in_sof = 1'b1; in_data = pix(32'h400, 0);
    #1 chk("midsof_ready", in_ready, 0);
    @(negedge clk);
    chk("midsof_err", err, 1);
    send(pix(32'h400, 0), 1'b1, w, rs);
    chk("midsof_waits", w, 5);
    chk("midsof_rsts", rs, 2);
    chk("midsof_err_clr", err, 0);
    part(32'h400, 1, 15, 1'b0);
    idle(8);
    chk("taps_de", tap_cnt, 33);

    // frame F: FIFO0 reports empty while row 1 is read
    part(32'h500, 0, 3, 1'b0);
    force_e = 1'b1;
    part(32'h500, 4, 4, 1'b0);
    chk("uflow_err_pre", err, 0);
    part(32'h500, 5, 5, 1'b0);
    chk("uflow_err", err, 1);
    part(32'h500, 6, 7, 1'b0);
    idle(1);
    force_e = 1'b0;
    part(32'h500, 8, 15, 1'b0);
    idle(4);
    chk("uflow_err_sticky", err, 1);
    part(32'h600, 0, 0, 1'b0);
    chk("uflow_err_clr", err, 0);
    part(32'h600, 1, 15, 1'b0);
    idle(8);
    chk("taps_fg", tap_cnt, 49);

    // frame H interrupted by reset during RUN
    part(32'h700, 0, 9, 1'b0);
    rst_n = 1'b0;
    #1 reset_vals("midrst");
    exp_q.delete();
    post_reset("midrst");
    part(32'h800, 0, 15, 1'b1);
    idle(8);
    chk("taps_i", tap_cnt, 57);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("occ_over_w", occ_viol, 0);
    chk("peak_f0", peak0, W);
    chk("peak_f1", peak1, W);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
